// File: rtl/tq4_row_sched_pkg.sv
// Shared tq definitions: datapath widths, multiplier latency, row tag and
// scheduler state encoding used by the 4/8/16/32-point row schedulers.
package tq4_row_sched_pkg;

  localparam int TQ_IN_W     = 19;
  localparam int TQ_MCM_W    = 28;
  localparam int TQ_MCM4_LAT = 2;

  typedef struct packed {
    logic       valid;
    logic [1:0] row;
    logic       last;
  } row_tag_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

  function automatic row_tag_t make_tag(input logic [1:0] row);
    make_tag.valid = 1'b1;
    make_tag.row   = row;
    make_tag.last  = (row == 2'd3);
  endfunction

endpackage

// File: rtl/tq4_row_sched_if.sv
// Bundle of the row-feeder handshake, multiplier side-band and result bus
// around the 4-point row scheduler.
interface tq4_row_sched_if
  import tq4_row_sched_pkg::*;
#(
  parameter int IN_W  = TQ_IN_W,
  parameter int OUT_W = TQ_MCM_W
) ();

  logic                    i_valid;
  logic                    o_ready;
  logic                    i_inverse;
  logic                    i_abort;
  logic signed [IN_W-1:0]  i_d0, i_d1, i_d2, i_d3;

  logic                    mcm_inverse;
  logic signed [IN_W-1:0]  mcm_i0, mcm_i1, mcm_i2, mcm_i3;
  logic signed [OUT_W-1:0] mcm_m0, mcm_m1, mcm_m2, mcm_m3;

  logic                    o_valid;
  logic [1:0]              o_row;
  logic                    o_last;
  logic                    o_done;
  logic signed [OUT_W-1:0] o_r0, o_r1, o_r2, o_r3;
  logic                    o_busy;

  modport master (
    output i_valid, i_inverse, i_abort, i_d0, i_d1, i_d2, i_d3,
    output mcm_m0, mcm_m1, mcm_m2, mcm_m3,
    input  o_ready, mcm_inverse, mcm_i0, mcm_i1, mcm_i2, mcm_i3,
    input  o_valid, o_row, o_last, o_done, o_r0, o_r1, o_r2, o_r3, o_busy
  );

  modport slave (
    input  i_valid, i_inverse, i_abort, i_d0, i_d1, i_d2, i_d3,
    input  mcm_m0, mcm_m1, mcm_m2, mcm_m3,
    output o_ready, mcm_inverse, mcm_i0, mcm_i1, mcm_i2, mcm_i3,
    output o_valid, o_row, o_last, o_done, o_r0, o_r1, o_r2, o_r3, o_busy
  );

endinterface

// File: rtl/tq4_row_sched_tag_pipe.sv
// Depth-N shift register of row tags that follows rows through a
// fixed-latency multiplier; clr empties every stage on the next edge.
module tq_tag_pipe
  import tq4_row_sched_pkg::*;
#(
  parameter int DEPTH = TQ_MCM4_LAT + 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  input  row_tag_t tag_in,
  output row_tag_t tag_out
);

  row_tag_t stage_q [DEPTH];
  row_tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/tq4_row_sched.sv
// Feeds one 4x4 block, row by row, into the free-running 4-point constant
// multiplier and re-tags its results with row index, last and done.
module tq4_row_sched
  import tq4_row_sched_pkg::*;
#(
  parameter int IN_W    = TQ_IN_W,
  parameter int OUT_W   = TQ_MCM_W,
  parameter int MCM_LAT = TQ_MCM4_LAT
) (
  input logic           clk,
  input logic           rst,
  tq4_row_sched_if.slave bus
);

  sched_state_t            state_q, state_d;
  logic [1:0]              row_cnt_q, row_cnt_d;
  logic                    inv_q, inv_d;
  logic                    mcm_inv_q, mcm_inv_d;
  logic signed [IN_W-1:0]  mcm_i_q [4];
  logic signed [IN_W-1:0]  mcm_i_d [4];
  logic signed [OUT_W-1:0] res_q [4];
  logic signed [OUT_W-1:0] res_d [4];
  logic [1:0]              o_row_q, o_row_d;
  logic                    o_last_q, o_last_d;
  logic                    o_valid_q, o_valid_d;
  logic                    o_done_q, o_done_d;
  row_tag_t                tag_in, tag_out;
  logic                    accept;

  assign bus.o_ready = (state_q == ST_IDLE || state_q == ST_ISSUE) && !bus.i_abort && !rst;
  assign accept      = bus.i_valid & bus.o_ready;

  // The tag leaving the last stage lines up with the multiplier output of its row.
  tq_tag_pipe #(.DEPTH(MCM_LAT + 1)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.i_abort),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    inv_d     = inv_q;
    mcm_inv_d = mcm_inv_q;
    mcm_i_d   = mcm_i_q;
    res_d     = res_q;
    o_row_d   = o_row_q;
    o_last_d  = o_last_q;
    o_valid_d = tag_out.valid;
    o_done_d  = tag_out.valid & tag_out.last;
    tag_in    = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          inv_d     = bus.i_inverse;
          row_cnt_d = 2'd1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          row_cnt_d = row_cnt_q + 2'd1;
          if (row_cnt_q == 2'd3) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tag_out.valid && tag_out.last) begin
          state_d   = ST_IDLE;
          row_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        row_cnt_d = '0;
      end
    endcase

    // Row 0 carries the block direction itself; later rows reuse the latched copy.
    if (accept) begin
      mcm_i_d   = '{bus.i_d0, bus.i_d1, bus.i_d2, bus.i_d3};
      mcm_inv_d = (state_q == ST_IDLE) ? bus.i_inverse : inv_q;
      tag_in    = make_tag(row_cnt_q);
    end

    if (tag_out.valid) begin
      res_d    = '{bus.mcm_m0, bus.mcm_m1, bus.mcm_m2, bus.mcm_m3};
      o_row_d  = tag_out.row;
      o_last_d = tag_out.last;
    end

    if (bus.i_abort) begin
      state_d   = ST_IDLE;
      row_cnt_d = '0;
      o_valid_d = 1'b0;
      o_done_d  = 1'b0;
      res_d     = res_q;
      o_row_d   = o_row_q;
      o_last_d  = o_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_cnt_q <= '0;
      inv_q     <= 1'b0;
      mcm_inv_q <= 1'b0;
      mcm_i_q   <= '{default: '0};
      res_q     <= '{default: '0};
      o_row_q   <= '0;
      o_last_q  <= 1'b0;
      o_valid_q <= 1'b0;
      o_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      inv_q     <= inv_d;
      mcm_inv_q <= mcm_inv_d;
      mcm_i_q   <= mcm_i_d;
      res_q     <= res_d;
      o_row_q   <= o_row_d;
      o_last_q  <= o_last_d;
      o_valid_q <= o_valid_d;
      o_done_q  <= o_done_d;
    end
  end

  assign bus.mcm_inverse = mcm_inv_q;
  assign bus.mcm_i0      = mcm_i_q[0];
  assign bus.mcm_i1      = mcm_i_q[1];
  assign bus.mcm_i2      = mcm_i_q[2];
  assign bus.mcm_i3      = mcm_i_q[3];
  assign bus.o_r0        = res_q[0];
  assign bus.o_r1        = res_q[1];
  assign bus.o_r2        = res_q[2];
  assign bus.o_r3        = res_q[3];
  assign bus.o_row       = o_row_q;
  assign bus.o_last      = o_last_q;
  assign bus.o_valid     = o_valid_q;
  assign bus.o_done      = o_done_q;
  assign bus.o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tq4_row_sched.sv
// Self-checking bench for tq4_row_sched: a 2-stage multiplier stub beside the
// DUT and a cycle-indexed expectation timeline built from accepted rows.
module tb_tq4_row_sched;
  import tq4_row_sched_pkg::*;

  localparam int LAT  = TQ_MCM4_LAT + 2;
  localparam int NCYC = 1024;
  localparam int COEF [4][4] = '{'{89,  75,  50,  18},
                                 '{75, -18, -89, -50},
                                 '{50, -89,  18,  75},
                                 '{18, -50,  75, -89}};

  logic clk = 1'b0;
  logic rst;

  tq4_row_sched_if bus ();

  tq4_row_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Forward: input j weights basis row 3-j; inverse uses the transposed weights.
  function automatic logic signed [27:0] mcm_out(input int d0, input int d1, input int d2,
                                                 input int d3, input logic inv, input int k);
    int d [4];
    int acc;
    d   = '{d0, d1, d2, d3};
    acc = 0;
    for (int j = 0; j < 4; j++) begin
      acc += inv ? d[j] * COEF[j][k] : d[j] * COEF[3-j][k];
    end
    return 28'(acc);
  endfunction

  logic signed [27:0] p1 [4];
  logic signed [27:0] pm [4];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      p1[k] <= mcm_out(int'(bus.mcm_i0), int'(bus.mcm_i1), int'(bus.mcm_i2),
                       int'(bus.mcm_i3), bus.mcm_inverse, k);
      pm[k] <= p1[k];
    end
  end

  assign bus.mcm_m0 = pm[0];
  assign bus.mcm_m1 = pm[1];
  assign bus.mcm_m2 = pm[2];
  assign bus.mcm_m3 = pm[3];

  // Expectation timeline, indexed by cycle number.
  logic               ev        [NCYC];
  logic [1:0]         erow      [NCYC];
  logic signed [27:0] eres      [NCYC][4];
  logic               eminv_chk [NCYC];
  logic               eminv     [NCYC];
  logic               ezero     [NCYC];
  logic signed [27:0] held_r    [4];

  int   cycle;
  int   busy_until;
  int   rows_in_block;
  logic blk_inv;
  int   n_pass;
  int   n_total;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
      $error("[TB] check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rnd19();
    logic signed [18:0] t;
    t = 19'($urandom);
    return int'(t);
  endfunction

  task automatic checkOutput();
    logic signed [27:0] r [4];
    r = '{bus.o_r0, bus.o_r1, bus.o_r2, bus.o_r3};
    chk("o_valid", bus.o_valid, ev[cycle]);
    if (ev[cycle]) begin
      chk("o_row", bus.o_row, erow[cycle]);
      chk("o_last", bus.o_last, erow[cycle] == 2'd3);
      chk("o_done", bus.o_done, erow[cycle] == 2'd3);
      for (int k = 0; k < 4; k++) held_r[k] = eres[cycle][k];
    end else begin
      chk("o_done_idle", bus.o_done, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("o_r%0d", k), r[k], held_r[k]);
    end
    if (eminv_chk[cycle]) chk("mcm_inverse", bus.mcm_inverse, eminv[cycle]);
    if (ezero[cycle]) begin
      chk("rst_o_row", bus.o_row, 2'd0);
      chk("rst_o_last", bus.o_last, 1'b0);
      chk("rst_mcm_inverse", bus.mcm_inverse, 1'b0);
      chk("rst_mcm_i", {bus.mcm_i0, bus.mcm_i1, bus.mcm_i2, bus.mcm_i3}, 64'd0);
    end
  endtask

  // One clock: drive inputs, check ready/busy, advance the model, check outputs.
  task automatic applyStimulus(input logic v, input logic inv, input logic ab, input logic r,
                               input int d0, input int d1, input int d2, input int d3);
    logic exp_ready;
    int   oc;
    bus.i_valid   = v;
    bus.i_inverse = inv;
    bus.i_abort   = ab;
    rst           = r;
    bus.i_d0      = 19'(d0);
    bus.i_d1      = 19'(d1);
    bus.i_d2      = 19'(d2);
    bus.i_d3      = 19'(d3);
    #1;
    exp_ready = !ab && !r && (cycle > busy_until);
    chk("o_ready", bus.o_ready, exp_ready);
    if (!r) chk("o_busy", bus.o_busy, (rows_in_block != 0) || (cycle <= busy_until));
    if (r || ab) begin
      for (int c = cycle + 1; c <= cycle + LAT; c++) ev[c] = 1'b0;
      rows_in_block = 0;
      busy_until    = cycle;
      if (r) begin
        for (int k = 0; k < 4; k++) held_r[k] = '0;
        ezero[cycle+1] = 1'b1;
      end
    end else if (v && exp_ready) begin
      if (rows_in_block == 0) blk_inv = inv;
      oc       = cycle + LAT;
      ev[oc]   = 1'b1;
      erow[oc] = 2'(rows_in_block);
      for (int k = 0; k < 4; k++) eres[oc][k] = mcm_out(d0, d1, d2, d3, blk_inv, k);
      eminv_chk[cycle+1] = 1'b1;
      eminv[cycle+1]     = blk_inv;
      if (rows_in_block == 3) begin
        busy_until    = cycle + LAT - 1;
        rows_in_block = 0;
      end else begin
        rows_in_block++;
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic rand_row(input logic v, input logic inv);
    applyStimulus(v, inv, 1'b0, 1'b0, rnd19(), rnd19(), rnd19(), rnd19());
  endtask

  initial begin
    logic gap_pat [7];
    for (int c = 0; c < NCYC; c++) begin
      ev[c] = 1'b0; erow[c] = '0; eminv_chk[c] = 1'b0; eminv[c] = 1'b0; ezero[c] = 1'b0;
      for (int k = 0; k < 4; k++) eres[c][k] = '0;
    end
    for (int k = 0; k < 4; k++) held_r[k] = '0;
    cycle = 0; busy_until = -1; rows_in_block = 0; blk_inv = 1'b0;
    n_pass = 0; n_total = 0;
    bus.i_valid = 1'b0; bus.i_inverse = 1'b0; bus.i_abort = 1'b0;
    bus.i_d0 = '0; bus.i_d1 = '0; bus.i_d2 = '0; bus.i_d3 = '0;
    rst = 1'b1;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
    idle(2);

    // Forward unit rows, with the known basis values checked directly.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1);
    chk("unit_row0_valid", bus.o_valid, 1'b1);
    chk("unit_row0_r0", bus.o_r0, 18);
    chk("unit_row0_r1", bus.o_r1, -50);
    chk("unit_row0_r2", bus.o_r2, 75);
    chk("unit_row0_r3", bus.o_r3, -89);
    idle(1);
    chk("unit_row1_r0", bus.o_r0, 50);
    chk("unit_row1_r1", bus.o_r1, -89);
    chk("unit_row1_r2", bus.o_r2, 18);
    chk("unit_row1_r3", bus.o_r3, 75);
    idle(4);

    // Inverse block: direction given on row 0 only.
    rand_row(1'b1, 1'b1);
    rand_row(1'b1, 1'b0);
    rand_row(1'b1, 1'b0);
    rand_row(1'b1, 1'b0);
    idle(5);

    // Input gaps preserved on the output.
    gap_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) rand_row(gap_pat[i], 1'(i));
    idle(5);

    // Drain blocking with two blocks queued and i_valid held high.
    for (int i = 0; i < 14; i++) rand_row(1'b1, 1'($urandom));
    idle(6);

    // Abort the cycle after the row-1 accept, then a clean block.
    rand_row(1'b1, 1'b0);
    rand_row(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, rnd19(), rnd19(), rnd19(), rnd19());
    idle(6);
    for (int i = 0; i < 4; i++) rand_row(1'b1, 1'b1);
    idle(6);

    // Reset while draining.
    for (int i = 0; i < 4; i++) rand_row(1'b1, 1'b0);
    idle(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
    idle(6);

    // Randomised traffic with occasional aborts.
    for (int i = 0; i < 120; i++) begin
      applyStimulus($urandom_range(3) != 0, 1'($urandom), $urandom_range(31) == 0, 1'b0,
                    rnd19(), rnd19(), rnd19(), rnd19());
    end
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
